// File: rtl/prf_free_list.sv
// prf_free_list: circular free list of integer physical register indices.
// Grants up to ALLOC_WIDTH registers per cycle to rename and accepts up to
// FREE_WIDTH released registers per cycle from retire. A head checkpoint is
// kept per branch checkpoint slot so a misprediction restores in one cycle.
// Optional protocol checking is enabled by defining PRF_FREE_LIST_ERR_CHECK_EN.

`ifndef PRF_INT_SIZE
`define PRF_INT_SIZE 64
`endif
`ifndef ARF_INT_SIZE
`define ARF_INT_SIZE 32
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef RAT_CP_SIZE
`define RAT_CP_SIZE 8
`endif

module prf_free_list #(
    parameter int PRF_SIZE    = `PRF_INT_SIZE,
    parameter int ARF_SIZE    = `ARF_INT_SIZE,
    parameter int ALLOC_WIDTH = `RENAME_WIDTH,
    parameter int FREE_WIDTH  = `COMMIT_WIDTH,
    parameter int CP_SIZE     = `RAT_CP_SIZE,
    localparam int DEPTH      = PRF_SIZE - ARF_SIZE,
    localparam int PW         = $clog2(PRF_SIZE),
    localparam int CW         = (CP_SIZE > 1) ? $clog2(CP_SIZE) : 1,
    localparam int DW         = $clog2(DEPTH),
    localparam int PTW        = DW + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ALLOC_WIDTH-1:0]           alloc_req,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]   alloc_prf,
    output logic                             alloc_ok,
    input  logic [FREE_WIDTH-1:0]            free_req,
    input  logic [FREE_WIDTH-1:0][PW-1:0]    free_prf,
    input  logic                             check,
    input  logic [CW-1:0]                    check_idx,
    input  logic                             recover,
    input  logic [CW-1:0]                    recover_idx,
    output logic [PTW-1:0]                   free_count,
    output logic                             err
);

    localparam int AW = $clog2(ALLOC_WIDTH + 1);
    localparam int FW = $clog2(FREE_WIDTH + 1);
    localparam logic [PTW-1:0] DEPTH_P = PTW'(DEPTH);

    // Storage and pointers; pointer MSB is the wrap bit
    logic [PW-1:0]  ram_r [DEPTH];
    logic [PTW-1:0] head_r;
    logic [PTW-1:0] tail_r;
    logic [PTW-1:0] free_count_r;
    logic [PTW-1:0] cp_r [CP_SIZE];

    // Combinational next-state and datapath signals
    logic [AW-1:0]                 n_alloc_s;
    logic [FW-1:0]                 n_free_s;
    logic                          alloc_ok_s;
    logic [ALLOC_WIDTH-1:0][PW-1:0] alloc_prf_s;
    logic [DW-1:0]                 wr_addr_s [FREE_WIDTH];
    logic [PTW-1:0]                head_nxt_s;
    logic [PTW-1:0]                tail_nxt_s;
    logic [PTW-1:0]                count_nxt_s;
    logic [PTW-1:0]                cp_rd_s;

    // Count requesting lanes on the allocate and free ports
    always_comb begin
        n_alloc_s = '0;
        n_free_s  = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            n_alloc_s = n_alloc_s + AW'(alloc_req[i]);
        end
        for (int i = 0; i < FREE_WIDTH; i++) begin
            n_free_s = n_free_s + FW'(free_req[i]);
        end
    end

    // Grant decision: all-or-nothing, blocked during a recovery
    always_comb begin
        alloc_ok_s = (!recover) && (32'(free_count_r) >= 32'(n_alloc_s));
    end

    // Each requesting lane reads the entry at head plus the number of
    // requesting lanes below it; idle lanes still show an entry (don't-care)
    always_comb begin
        logic [PTW-1:0] off_v;
        off_v       = '0;
        alloc_prf_s = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_prf_s[i] = ram_r[DW'(head_r + off_v)];
            off_v          = off_v + PTW'(alloc_req[i]);
        end
    end

    // Released indices are packed in lane order starting at tail
    always_comb begin
        logic [PTW-1:0] off_v;
        off_v = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            wr_addr_s[i] = DW'(tail_r + off_v);
            off_v        = off_v + PTW'(free_req[i]);
        end
    end

    // Next head, tail and occupancy; recovery overrides any grant
    always_comb begin
        tail_nxt_s = tail_r + PTW'(n_free_s);
        cp_rd_s    = cp_r[recover_idx];
        if (recover) begin
            head_nxt_s  = cp_rd_s;
            count_nxt_s = tail_nxt_s - cp_rd_s;
        end else if (alloc_ok_s) begin
            head_nxt_s  = head_r + PTW'(n_alloc_s);
            count_nxt_s = free_count_r - PTW'(n_alloc_s) + PTW'(n_free_s);
        end else begin
            head_nxt_s  = head_r;
            count_nxt_s = free_count_r + PTW'(n_free_s);
        end
    end

    // Pointer, occupancy and checkpoint table update
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r       <= '0;
            tail_r       <= DEPTH_P;
            free_count_r <= DEPTH_P;
            for (int k = 0; k < CP_SIZE; k++) begin
                cp_r[k] <= '0;
            end
        end else begin
            head_r       <= head_nxt_s;
            tail_r       <= tail_nxt_s;
            free_count_r <= count_nxt_s;
            if (check && !recover) begin
                cp_r[check_idx] <= head_nxt_s;
            end
        end
    end

    // List storage: preloaded with the registers not mapped at reset,
    // then written by the free lanes; writes are visible next cycle only
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ram_r[k] <= PW'(ARF_SIZE + k);
            end
        end else begin
            for (int i = 0; i < FREE_WIDTH; i++) begin
                if (free_req[i]) begin
                    ram_r[wr_addr_s[i]] <= free_prf[i];
                end
            end
        end
    end

    assign alloc_ok   = alloc_ok_s;
    assign alloc_prf  = alloc_prf_s;
    assign free_count = free_count_r;

`ifdef PRF_FREE_LIST_ERR_CHECK_EN
    localparam int PTW1 = PTW + 1;

    logic            err_r;
    logic            err_hit_s;
    logic [PTW1-1:0] count_wide_s;

    // Detect overflow, out-of-range indices, duplicate frees and
    // simultaneous check/recover; overflow is computed one bit wider
    always_comb begin
        if (recover) begin
            count_wide_s = {1'b0, count_nxt_s};
        end else begin
            count_wide_s = {1'b0, free_count_r}
                         - (alloc_ok_s ? PTW1'(n_alloc_s) : PTW1'(0))
                         + PTW1'(n_free_s);
        end
        err_hit_s = (count_wide_s > PTW1'(DEPTH)) | (recover & check);
        for (int i = 0; i < FREE_WIDTH; i++) begin
            err_hit_s = err_hit_s | (free_req[i] & (32'(free_prf[i]) >= 32'(PRF_SIZE)));
            for (int j = i + 1; j < FREE_WIDTH; j++) begin
                err_hit_s = err_hit_s | (free_req[i] & free_req[j] & (free_prf[i] == free_prf[j]));
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_hit_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
